// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, instruction field
// positions and the opcode classification used to pick the destination register.
package mips_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_REG_COUNT = 32;
    localparam int INSTR_W       = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SUB  = 6'b100010;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    typedef enum logic [1:0] {
        CLS_RTYPE    = 2'd0,
        CLS_WRITE_RT = 2'd1,
        CLS_NO_WRITE = 2'd2
    } op_class_e;

    typedef enum logic [1:0] {
        UPD_CLEAR = 2'd0,
        UPD_HOLD  = 2'd1,
        UPD_LOAD  = 2'd2
    } upd_sel_e;

    // Which register (if any) an opcode writes back.
    function automatic op_class_e classify_op(input logic [5:0] op);
        op_class_e cls;
        case (op)
            OP_RTYPE:                        cls = CLS_RTYPE;
            OP_ADDI, OP_ADDIU, OP_LW, OP_LBU: cls = CLS_WRITE_RT;
            default:                         cls = CLS_NO_WRITE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch-side instruction/control, write-back port and the
// registered operands presented to the ALU.
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
);
    logic              instr_valid;
    logic [31:0]       instruction;
    logic              stall;
    logic              flush;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        shmat;
    logic [5:0]        opcode;
    logic [5:0]        functioncode;
    logic [AW-1:0]     dest_reg;
    logic              reg_write;
    logic              out_valid;

    modport master (
        output instr_valid, instruction, stall, flush, wb_en, wb_addr, wb_data,
        input  read_data_1, read_data_2, store_data, shmat, opcode,
               functioncode, dest_reg, reg_write, out_valid
    );

    modport slave (
        input  instr_valid, instruction, stall, flush, wb_en, wb_addr, wb_data,
        output read_data_1, read_data_2, store_data, shmat, opcode,
               functioncode, dest_reg, reg_write, out_valid
    );
endinterface

// File: rtl/mips_regfile.sv
// 2-read/1-write register file; $0 is hardwired to zero and reads bypass a
// same-cycle write so the decoder sees the value being written back.
module mips_regfile #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int AW        = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra1_i,
    input  logic [AW-1:0]     ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic              wr_live_s;

    assign wr_live_s = we_i && (wa_i != '0);

    // Register array: cleared on reset, written when the target is not $0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live_s) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read port 1 with $0 forcing and write bypass.
    always_comb begin
        rd1_o = '0;
        if (ra1_i == '0) begin
            rd1_o = '0;
        end else if (wr_live_s && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end else begin
            rd1_o = regs_q[ra1_i];
        end
    end

    // Read port 2 with $0 forcing and write bypass.
    always_comb begin
        rd2_o = '0;
        if (ra2_i == '0) begin
            rd2_o = '0;
        end else if (wr_live_s && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end else begin
            rd2_o = regs_q[ra2_i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode / operand-fetch stage: splits the instruction, reads
// operands, and registers everything the ALU and write-back need.
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int REG_COUNT = DEF_REG_COUNT
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);

    localparam int AW = $clog2(REG_COUNT);

    logic [5:0]        opcode_s;
    logic [AW-1:0]     rs_s;
    logic [AW-1:0]     rt_s;
    logic [AW-1:0]     rd_s;
    logic [4:0]        shmat_s;
    logic [5:0]        funct_s;
    logic [IMM_W-1:0]  imm_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic              wb_live_s;
    logic              hit_rs_s;
    logic              hit_rt_s;
    upd_sel_e          upd_sel_s;

    logic [DATA_W-1:0] rd1_q,   rd1_d;
    logic [DATA_W-1:0] rd2_q,   rd2_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [4:0]        shmat_q, shmat_d;
    logic [5:0]        op_q,    op_d;
    logic [5:0]        fn_q,    fn_d;
    logic [AW-1:0]     dest_q,  dest_d;
    logic              regw_q,  regw_d;
    logic              valid_q, valid_d;
    logic [AW-1:0]     rs_q,    rs_d;
    logic [AW-1:0]     rt_q,    rt_d;

    assign opcode_s = bus.instruction[OPC_LSB +: 6];
    assign rs_s     = bus.instruction[RS_LSB +: AW];
    assign rt_s     = bus.instruction[RT_LSB +: AW];
    assign rd_s     = bus.instruction[RD_LSB +: AW];
    assign shmat_s  = bus.instruction[SH_LSB +: 5];
    assign funct_s  = bus.instruction[FN_LSB +: 6];
    assign imm_s    = bus.instruction[IMM_LSB +: IMM_W];

    mips_regfile #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT),
        .AW        (AW)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1_i (rs_s),
        .ra2_i (rt_s),
        .rd1_o (rs_val_s),
        .rd2_o (rt_val_s),
        .we_i  (bus.wb_en),
        .wa_i  (bus.wb_addr),
        .wd_i  (bus.wb_data)
    );

    // A held instruction must track write-backs to its sources while stalled.
    assign wb_live_s = bus.wb_en && (bus.wb_addr != '0);
    assign hit_rs_s  = wb_live_s && (bus.wb_addr == rs_q);
    assign hit_rt_s  = wb_live_s && (bus.wb_addr == rt_q);

    // Update selection: flush beats stall, stall beats a new instruction.
    always_comb begin
        upd_sel_s = UPD_CLEAR;
        if (bus.flush) begin
            upd_sel_s = UPD_CLEAR;
        end else if (bus.stall) begin
            upd_sel_s = UPD_HOLD;
        end else if (bus.instr_valid) begin
            upd_sel_s = UPD_LOAD;
        end else begin
            upd_sel_s = UPD_CLEAR;
        end
    end

    // Next-state of the pipeline register; the clear path is the default.
    always_comb begin
        rd1_d   = '0;
        rd2_d   = '0;
        store_d = '0;
        shmat_d = 5'd0;
        op_d    = 6'd0;
        fn_d    = 6'd0;
        dest_d  = '0;
        regw_d  = 1'b0;
        valid_d = 1'b0;
        rs_d    = '0;
        rt_d    = '0;
        case (upd_sel_s)
            UPD_HOLD: begin
                shmat_d = shmat_q;
                op_d    = op_q;
                fn_d    = fn_q;
                dest_d  = dest_q;
                regw_d  = regw_q;
                valid_d = valid_q;
                rs_d    = rs_q;
                rt_d    = rt_q;
                if (hit_rs_s) begin
                    rd1_d = bus.wb_data;
                end else begin
                    rd1_d = rd1_q;
                end
                if (hit_rt_s) begin
                    store_d = bus.wb_data;
                end else begin
                    store_d = store_q;
                end
                if (hit_rt_s && (op_q == OP_RTYPE)) begin
                    rd2_d = bus.wb_data;
                end else begin
                    rd2_d = rd2_q;
                end
            end
            UPD_LOAD: begin
                rd1_d   = rs_val_s;
                store_d = rt_val_s;
                shmat_d = shmat_s;
                op_d    = opcode_s;
                fn_d    = funct_s;
                valid_d = 1'b1;
                rs_d    = rs_s;
                rt_d    = rt_s;
                if (opcode_s == OP_RTYPE) begin
                    rd2_d = rt_val_s;
                end else begin
                    rd2_d = {{(DATA_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
                end
                case (classify_op(opcode_s))
                    CLS_RTYPE: begin
                        dest_d = rd_s;
                        regw_d = (rd_s != '0);
                    end
                    CLS_WRITE_RT: begin
                        dest_d = rt_s;
                        regw_d = (rt_s != '0);
                    end
                    default: begin
                        dest_d = rt_s;
                        regw_d = 1'b0;
                    end
                endcase
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_q   <= '0;
            rd2_q   <= '0;
            store_q <= '0;
            shmat_q <= 5'd0;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
            dest_q  <= '0;
            regw_q  <= 1'b0;
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
        end else begin
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            store_q <= store_d;
            shmat_q <= shmat_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            dest_q  <= dest_d;
            regw_q  <= regw_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
        end
    end

    assign bus.read_data_1  = rd1_q;
    assign bus.read_data_2  = rd2_q;
    assign bus.store_data   = store_q;
    assign bus.shmat        = shmat_q;
    assign bus.opcode       = op_q;
    assign bus.functioncode = fn_q;
    assign bus.dest_reg     = dest_q;
    assign bus.reg_write    = regw_q;
    assign bus.out_valid    = valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboarded bench for decode_stage: directed scenarios plus randomized
// traffic checked against a register-array reference model.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] st;
        logic [4:0]  sh;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  dest;
        logic        regw;
        logic        valid;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc;

    exp_t        sb_q[$];
    logic [31:0] ref_regs [32];
    logic [31:0] cur_instr;
    logic        cur_valid;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs for an instruction, computed from the current register contents.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic v);
        exp_t e;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        e.rd1 = ref_regs[rs];
        e.st  = ref_regs[rt];
        e.rd2 = (op == 6'd0) ? ref_regs[rt] : {{16{ins[15]}}, ins[15:0]};
        e.sh  = ins[10:6];
        e.op  = op;
        e.fn  = ins[5:0];
        e.valid = 1'b1;
        if (op == 6'd0) begin
            e.dest = rd;
            e.regw = (rd != 5'd0);
        end else if (op == 6'b001000 || op == 6'b001001 || op == 6'b100011 || op == 6'b100100) begin
            e.dest = rt;
            e.regw = (rt != 5'd0);
        end else begin
            e.dest = rt;
            e.regw = 1'b0;
        end
        if (!v) e = '0;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        cur_instr = 32'd0;
        cur_valid = 1'b0;
    endtask

    // Drive one cycle of inputs, push the expected post-edge outputs, wait for the edge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic st, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        bus.instr_valid = iv;
        bus.instruction = ins;
        bus.stall       = st;
        bus.flush       = fl;
        bus.wb_en       = we;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
        if (we && wa != 5'd0) ref_regs[wa] = wd;
        if (fl) begin
            cur_instr = 32'd0;
            cur_valid = 1'b0;
        end else if (st) begin
            cur_instr = cur_instr;
        end else if (iv) begin
            cur_instr = ins;
            cur_valid = 1'b1;
        end else begin
            cur_instr = 32'd0;
            cur_valid = 1'b0;
        end
        sb_q.push_back(ref_decode(cur_instr, cur_valid));
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, wa, wd);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rd1"}, bus.read_data_1, 32'd0);
        chk({name, "_rd2"}, bus.read_data_2, 32'd0);
        chk({name, "_st"},  bus.store_data, 32'd0);
        chk({name, "_op"},  {26'd0, bus.opcode}, 32'd0);
        chk({name, "_dst"}, {27'd0, bus.dest_reg}, 32'd0);
        chk({name, "_vld"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    // Monitor: pops the scoreboard after each active edge and compares every output.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_rd1",  bus.read_data_1, e.rd1);
            chk("sb_rd2",  bus.read_data_2, e.rd2);
            chk("sb_st",   bus.store_data, e.st);
            chk("sb_sh",   {27'd0, bus.shmat}, {27'd0, e.sh});
            chk("sb_op",   {26'd0, bus.opcode}, {26'd0, e.op});
            chk("sb_fn",   {26'd0, bus.functioncode}, {26'd0, e.fn});
            chk("sb_dest", {27'd0, bus.dest_reg}, {27'd0, e.dest});
            chk("sb_regw", {31'd0, bus.reg_write}, {31'd0, e.regw});
            chk("sb_vld",  {31'd0, bus.out_valid}, {31'd0, e.valid});
        end
    end

    initial begin
        logic [5:0]  ops [7];
        logic [31:0] ins;
        logic [5:0]  op;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        ops[0] = 6'b000000; ops[1] = 6'b001000; ops[2] = 6'b001001; ops[3] = 6'b100011;
        ops[4] = 6'b100100; ops[5] = 6'b101011; ops[6] = 6'b000000;
        model_clear();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instruction = 32'd0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.wb_en = 1'b0;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'd0;
        #1;
        chk_all_zero("rst_init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted while a valid instruction is held.
        wr(5'd1, 32'h0000_0011);
        step(1'b1, 32'h0022_1820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 32'h0022_1820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("pre_rst_vld", {31'd0, bus.out_valid}, 32'd1);
        bus.stall = 1'b1;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h0022_1820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("tp1_rd1", bus.read_data_1, 32'd0);
        chk("tp1_rd2", bus.read_data_2, 32'd0);
        chk("tp1_dest", {27'd0, bus.dest_reg}, 32'd3);
        chk("tp1_regw", {31'd0, bus.reg_write}, 32'd1);
        chk("tp1_fn", {26'd0, bus.functioncode}, 32'h20);

        // R-type decode and sll.
        wr(5'd1, 32'h8000_0005);
        wr(5'd2, 32'h0000_000D);
        step(1'b1, 32'h0022_1820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("tp2_rd1", bus.read_data_1, 32'h8000_0005);
        chk("tp2_rd2", bus.read_data_2, 32'h0000_000D);
        chk("tp2_op", {26'd0, bus.opcode}, 32'd0);
        chk("tp2_vld", {31'd0, bus.out_valid}, 32'd1);
        step(1'b1, 32'h0002_20C0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("tp2_sh", {27'd0, bus.shmat}, 32'd3);
        chk("tp2_sll_rd2", bus.read_data_2, 32'h0000_000D);
        chk("tp2_sll_dest", {27'd0, bus.dest_reg}, 32'd4);

        // I-type sign extension.
        wr(5'd1, 32'h8000_0004);
        step(1'b1, 32'h2025_FFFC, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("tp3_rd1", bus.read_data_1, 32'h8000_0004);
        chk("tp3_rd2", bus.read_data_2, 32'hFFFF_FFFC);
        chk("tp3_dest", {27'd0, bus.dest_reg}, 32'd5);
        chk("tp3_regw", {31'd0, bus.reg_write}, 32'd1);
        chk("tp3_op", {26'd0, bus.opcode}, 32'h08);

        // Same-cycle bypass and hardwired $0.
        step(1'b1, 32'h0022_1820, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1234_5678);
        chk("tp4_bypass", bus.read_data_1, 32'h1234_5678);
        wr(5'd0, 32'hFFFF_FFFF);
        step(1'b1, 32'h0000_1820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("tp4_r0", bus.read_data_1, 32'd0);

        // Held-operand refresh under stall.
        wr(5'd1, 32'd5);
        step(1'b1, 32'h0022_1820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 32'h2025_FFFC, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_00AA);
        chk("tp5_rd2", bus.read_data_2, 32'h0000_00AA);
        chk("tp5_st", bus.store_data, 32'h0000_00AA);
        chk("tp5_rd1", bus.read_data_1, 32'd5);
        chk("tp5_op_hold", {26'd0, bus.opcode}, 32'd0);
        step(1'b1, 32'h0002_20C0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("tp5_release_dest", {27'd0, bus.dest_reg}, 32'd4);
        chk("tp5_release_rd2", bus.read_data_2, 32'h0000_00AA);

        // Flush beats stall; idle input is a bubble.
        step(1'b1, 32'h2025_FFFC, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("tp6_vld", {31'd0, bus.out_valid}, 32'd0);
        chk("tp6_regw", {31'd0, bus.reg_write}, 32'd0);
        chk("tp6_op", {26'd0, bus.opcode}, 32'd0);
        chk("tp6_fn", {26'd0, bus.functioncode}, 32'd0);
        step(1'b1, 32'h2025_FFFC, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'h2025_FFFC, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("tp6_bubble_vld", {31'd0, bus.out_valid}, 32'd0);

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            if (op == 6'd0) begin
                ins = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)};
            end else begin
                ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            end
            step(($urandom_range(0, 9) < 8), ins, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)), $urandom);
        end

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
